fetch_sequencer: RTL and testbench

//  Multi-cycle fetch controller for the Y86-64 core. Reads one instruction byte per request from a

---
 rtl/fetch_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 fetch controller: reads one instruction byte per memory request,
// assembles icode/ifun/rA/rB/valC, issues to decode and waits for the next PC.
module fetch_sequencer #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_rd_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [7:0]  imem_data_i,
    output logic        issue_valid_o,
    input  logic        issue_ready_i,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [63:0] valc_o,
    output logic [63:0] valp_o,
    output logic [63:0] pc_o,
    input  logic        newpc_valid_i,
    input  logic [63:0] newpc_i,
    output logic [1:0]  stat_o
);

    typedef enum logic [2:0] {
        S_REQ, S_WAIT_BYTE, S_ISSUE, S_WAIT_PC, S_HALT, S_ERR
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic [1:0]  stat_q, stat_d;
    logic        rd_q, rd_d;
    logic [63:0] addr_q, addr_d;

    logic [63:0] byte_addr;
    logic [3:0]  byte_len;
    logic [3:0]  n_next;
    logic        has_regs;
    logic [2:0]  vidx;
    logic        accept;

    function automatic logic [3:0] insn_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:             insn_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:       insn_len = 4'd2;
            4'h7, 4'h8:                   insn_len = 4'd9;
            default:                      insn_len = 4'd10;
        endcase
    endfunction

    assign byte_addr = pc_q + {60'd0, n_q};
    assign byte_len  = insn_len(imem_data_i[7:4]);
    assign n_next    = n_q + 4'd1;
    assign has_regs  = (len_q == 4'd2) || (len_q == 4'd10);
    assign vidx      = n_q[2:0] - (has_regs ? 3'd2 : 3'd1);
    // Data is never returned in the request cycle, so anything arriving then is stale.
    assign accept    = imem_valid_i && !rd_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        len_d   = len_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        stat_d  = stat_q;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            S_REQ: begin
                if (byte_addr >= 64'(IMEM_DEPTH)) begin
                    state_d = S_ERR;
                    stat_d  = STAT_ADR;
                end else begin
                    rd_d    = 1'b1;
                    addr_d  = byte_addr;
                    state_d = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (accept) begin
                    if (n_q == 4'd0) begin
                        if (imem_data_i[7:4] > 4'hB) begin
                            state_d = S_ERR;
                            stat_d  = STAT_INS;
                        end else begin
                            icode_d = imem_data_i[7:4];
                            ifun_d  = imem_data_i[3:0];
                            ra_d    = 4'hF;
                            rb_d    = 4'hF;
                            valc_d  = 64'd0;
                            len_d   = byte_len;
                            if (byte_len == 4'd1) begin
                                valp_d  = pc_q + 64'd1;
                                state_d = S_ISSUE;
                            end else begin
                                n_d     = 4'd1;
                                state_d = S_REQ;
                            end
                        end
                    end else begin
                        if (has_regs && (n_q == 4'd1)) begin
                            ra_d = imem_data_i[7:4];
                            rb_d = imem_data_i[3:0];
                        end else begin
                            valc_d[{vidx, 3'b000} +: 8] = imem_data_i;
                        end
                        if (n_next == len_q) begin
                            valp_d  = pc_q + {60'd0, len_q};
                            state_d = S_ISSUE;
                        end else begin
                            n_d     = n_next;
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (issue_ready_i) begin
                    if (icode_q == 4'h0) begin
                        state_d = S_HALT;
                        stat_d  = STAT_HLT;
                    end else begin
                        state_d = S_WAIT_PC;
                    end
                end
            end
            S_WAIT_PC: begin
                if (newpc_valid_i) begin
                    pc_d    = newpc_i;
                    n_d     = 4'd0;
                    state_d = S_REQ;
                end
            end
            S_HALT, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            n_q     <= 4'd0;
            len_q   <= 4'd0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
            stat_q  <= STAT_AOK;
            rd_q    <= 1'b0;
            addr_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            len_q   <= len_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            stat_q  <= stat_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign imem_rd_o     = rd_q;
    assign imem_addr_o   = addr_q;
    assign issue_valid_o = (state_q == S_ISSUE);
    assign icode_o       = icode_q;
    assign ifun_o        = ifun_q;
    assign ra_o          = ra_q;
    assign rb_o          = rb_q;
    assign valc_o        = valc_q;
    assign valp_o        = valp_q;
    assign pc_o          = pc_q;
    assign stat_o        = stat_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed corner sequences, a decode vector table and
// randomized programs checked against a byte-level decode model.
module tb_fetch_sequencer;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_rd;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [7:0]  imem_data = 8'h00;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc_w;
    logic        newpc_valid = 1'b0;
    logic [63:0] newpc = 64'd0;
    logic [1:0]  stat;

    always #5 clk = ~clk;

    fetch_sequencer #(.IMEM_DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_rd_o(imem_rd), .imem_addr_o(imem_addr),
        .imem_valid_i(imem_valid), .imem_data_i(imem_data),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .icode_o(icode), .ifun_o(ifun), .ra_o(ra), .rb_o(rb),
        .valc_o(valc), .valp_o(valp), .pc_o(pc_w),
        .newpc_valid_i(newpc_valid), .newpc_i(newpc),
        .stat_o(stat)
    );

    logic [7:0] mem [0:DEPTH-1];
    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int iv_cycles = 0;
    bit auto_en = 1'b1;
    int dly_max = 1;

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
    } fields_t;

    typedef struct packed {
        logic [79:0] bytes;
        logic [3:0]  nbytes;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc;
    } vec_t;

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_rd) rd_count++;
            if (issue_valid) iv_cycles++;
        end
    end

    // Memory responder: one outstanding read, data 1..dly_max cycles after the request.
    initial begin
        logic [63:0] a;
        int d;
        forever begin
            @(posedge clk); #1;
            if (auto_en && !rst && imem_rd) begin
                a = imem_addr;
                d = $urandom_range(dly_max, 1);
                repeat (d) @(posedge clk);
                #1;
                imem_valid = 1'b1;
                imem_data  = mem[a[9:0]];
                @(posedge clk); #1;
                imem_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic fields_t model(input logic [63:0] pc);
        fields_t f;
        int p, len, off;
        logic [7:0] b0, b1;
        p  = int'(pc[9:0]);
        b0 = mem[p];
        f.icode = b0[7:4];
        f.ifun  = b0[3:0];
        f.ra    = 4'hF;
        f.rb    = 4'hF;
        f.valc  = 64'd0;
        case (b0[7:4])
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            default:                len = 10;
        endcase
        off = 1;
        if (len == 2 || len == 10) begin
            b1   = mem[p + 1];
            f.ra = b1[7:4];
            f.rb = b1[3:0];
            off  = 2;
        end
        if (len >= 9)
            for (int i = 0; i < 8; i++)
                f.valc = f.valc | (64'(mem[p + off + i]) << (8 * i));
        f.valp = pc + 64'(len);
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_vals);
        rst = 1'b1;
        issue_ready = 1'b0;
        newpc_valid = 1'b0;
        tick(3);
        if (check_vals) begin
            chk("rst_pc", pc_w, 64'd0);
            chk("rst_stat", 64'(stat), 64'd0);
            chk("rst_issue_valid", 64'(issue_valid), 64'd0);
            chk("rst_imem_rd", 64'(imem_rd), 64'd0);
            chk("rst_ra", 64'(ra), 64'hF);
            chk("rst_rb", 64'(rb), 64'hF);
            chk("rst_valp", valp, 64'd0);
            chk("rst_valc", valc, 64'd0);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (issue_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=no_issue required=issue");
        end
    endtask

    task automatic handshake(input int rdy_max);
        repeat ($urandom_range(rdy_max, 0)) @(posedge clk);
        @(posedge clk); #1;
        issue_ready = 1'b1;
        @(posedge clk); #1;
        issue_ready = 1'b0;
    endtask

    task automatic give_pc(input logic [63:0] v);
        @(posedge clk); #1;
        newpc_valid = 1'b1;
        newpc       = v;
        @(posedge clk); #1;
        newpc_valid = 1'b0;
    endtask

    task automatic fetch_model(input logic [63:0] pc, input int rdy_max);
        bit ok;
        fields_t g;
        wait_issue(ok);
        if (ok) begin
            g = model(pc);
            chk("rnd_icode", 64'(icode), 64'(g.icode));
            chk("rnd_ifun", 64'(ifun), 64'(g.ifun));
            chk("rnd_ra", 64'(ra), 64'(g.ra));
            chk("rnd_rb", 64'(rb), 64'(g.rb));
            chk("rnd_valc", valc, g.valc);
            chk("rnd_valp", valp, g.valp);
            chk("rnd_pc", pc_w, pc);
        end
        handshake(rdy_max);
    endtask

    task automatic wait_rd(output bit ok, output logic [63:0] a);
        ok = 1'b0;
        a  = 64'd0;
        for (int k = 0; k < 20; k++) begin
            if (imem_rd) begin
                ok = 1'b1;
                a  = imem_addr;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout actual=no_request required=request");
        end
    endtask

    initial begin
        vec_t vecs [12];
        logic [63:0] base, a;
        bit ok;
        int rd0, iv0;
        logic [79:0] irm;

        vecs[0]  = '{bytes: 80'h1000_0000_0000_0000_0000, nbytes: 4'd1,  icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0};
        vecs[1]  = '{bytes: 80'h6012_0000_0000_0000_0000, nbytes: 4'd2,  icode: 4'h6, ifun: 4'h0, ra: 4'h1, rb: 4'h2, valc: 64'h0};
        vecs[2]  = '{bytes: 80'h30F3_EFCD_AB89_6745_2301, nbytes: 4'd10, icode: 4'h3, ifun: 4'h0, ra: 4'hF, rb: 4'h3, valc: 64'h0123456789ABCDEF};
        vecs[3]  = '{bytes: 80'h7088_7766_5544_3322_1100, nbytes: 4'd9,  icode: 4'h7, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h1122334455667788};
        vecs[4]  = '{bytes: 80'h8010_0000_0000_0000_0000, nbytes: 4'd9,  icode: 4'h8, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h10};
        vecs[5]  = '{bytes: 80'h9000_0000_0000_0000_0000, nbytes: 4'd1,  icode: 4'h9, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0};
        vecs[6]  = '{bytes: 80'h4045_0800_0000_0000_0000, nbytes: 4'd10, icode: 4'h4, ifun: 4'h0, ra: 4'h4, rb: 4'h5, valc: 64'h8};
        vecs[7]  = '{bytes: 80'h24AB_0000_0000_0000_0000, nbytes: 4'd2,  icode: 4'h2, ifun: 4'h4, ra: 4'hA, rb: 4'hB, valc: 64'h0};
        vecs[8]  = '{bytes: 80'hA06F_0000_0000_0000_0000, nbytes: 4'd2,  icode: 4'hA, ifun: 4'h0, ra: 4'h6, rb: 4'hF, valc: 64'h0};
        vecs[9]  = '{bytes: 80'hB07F_0000_0000_0000_0000, nbytes: 4'd2,  icode: 4'hB, ifun: 4'h0, ra: 4'h7, rb: 4'hF, valc: 64'h0};
        vecs[10] = '{bytes: 80'h5121_F0FF_FFFF_FFFF_FFFF, nbytes: 4'd10, icode: 4'h5, ifun: 4'h1, ra: 4'h2, rb: 4'h1, valc: 64'hFFFFFFFFFFFFFFF0};
        vecs[11] = '{bytes: 80'h7101_0203_0405_0607_0800, nbytes: 4'd9,  icode: 4'h7, ifun: 4'h1, ra: 4'hF, rb: 4'hF, valc: 64'h0807060504030201};
        irm = 80'h30F3_EFCD_AB89_6745_2301;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

        // nop then halt
        mem[0] = 8'h10;
        mem[1] = 8'h00;
        do_reset(1'b1);
        wait_issue(ok);
        if (ok) begin
            chk("t1_icode", 64'(icode), 64'h1);
            chk("t1_ra", 64'(ra), 64'hF);
            chk("t1_rb", 64'(rb), 64'hF);
            chk("t1_valp", valp, 64'd1);
        end
        handshake(0);
        give_pc(64'd1);
        wait_issue(ok);
        if (ok) begin
            chk("t1_halt_icode", 64'(icode), 64'h0);
            chk("t1_halt_valp", valp, 64'd2);
        end
        handshake(0);
        tick(2);
        chk("t1_stat_hlt", 64'(stat), 64'd1);
        rd0 = rd_count;
        tick(20);
        chk("t1_no_rd_after_halt", 64'(rd_count), 64'(rd0));
        chk("t1_no_issue_after_halt", 64'(issue_valid), 64'd0);

        // irmovq, 10 reads
        for (int j = 0; j < 10; j++) mem[j] = irm[79 - 8*j -: 8];
        dly_max = 2;
        do_reset(1'b0);
        rd0 = rd_count;
        wait_issue(ok);
        if (ok) begin
            chk("t2_icode", 64'(icode), 64'h3);
            chk("t2_ra", 64'(ra), 64'hF);
            chk("t2_rb", 64'(rb), 64'h3);
            chk("t2_valc", valc, 64'h0123456789ABCDEF);
            chk("t2_valp", valp, 64'd10);
            chk("t2_rd_pulses", 64'(rd_count - rd0), 64'd10);
        end
        handshake(0);

        // issue held with ready low; newpc during ISSUE ignored
        mem[64] = 8'h60;
        mem[65] = 8'h12;
        give_pc(64'd64);
        wait_issue(ok);
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                chk("t3_issue_valid", 64'(issue_valid), 64'd1);
                chk("t3_icode", 64'(icode), 64'h6);
                chk("t3_ra", 64'(ra), 64'h1);
                chk("t3_rb", 64'(rb), 64'h2);
                chk("t3_valc", valc, 64'd0);
                chk("t3_valp", valp, 64'd66);
                chk("t3_pc", pc_w, 64'd64);
                newpc_valid = (k == 2);
                newpc       = 64'd768;
                @(negedge clk);
            end
        end
        newpc_valid = 1'b0;
        handshake(0);
        rd0 = rd_count;
        tick(4);
        chk("t3_pc_kept", pc_w, 64'd64);
        chk("t3_no_rd_in_wait_pc", 64'(rd_count), 64'(rd0));

        // decode vector table
        dly_max = 3;
        for (int i = 0; i < 12; i++) begin
            base = 64'(128 + 16 * i);
            for (int j = 0; j < int'(vecs[i].nbytes); j++)
                mem[int'(base) + j] = vecs[i].bytes[79 - 8*j -: 8];
            give_pc(base);
            wait_issue(ok);
            if (ok) begin
                chk("vec_icode", 64'(icode), 64'(vecs[i].icode));
                chk("vec_ifun", 64'(ifun), 64'(vecs[i].ifun));
                chk("vec_ra", 64'(ra), 64'(vecs[i].ra));
                chk("vec_rb", 64'(rb), 64'(vecs[i].rb));
                chk("vec_valc", valc, vecs[i].valc);
                chk("vec_valp", valp, base + 64'(vecs[i].nbytes));
                chk("vec_pc", pc_w, base);
            end
            handshake(1);
        end

        // jXX straddling the end of memory
        mem[1020] = 8'h70;
        mem[1021] = 8'h11;
        mem[1022] = 8'h22;
        mem[1023] = 8'h33;
        rd0 = rd_count;
        iv0 = iv_cycles;
        give_pc(64'd1020);
        tick(60);
        chk("t4_stat_adr", 64'(stat), 64'd2);
        chk("t4_rd_pulses", 64'(rd_count - rd0), 64'd4);
        chk("t4_no_issue", 64'(iv_cycles - iv0), 64'd0);
        rd0 = rd_count;
        tick(10);
        chk("t4_no_rd_after_adr", 64'(rd_count), 64'(rd0));

        // illegal opcode
        mem[0] = 8'hC0;
        do_reset(1'b0);
        iv0 = iv_cycles;
        tick(30);
        chk("t5_stat_ins", 64'(stat), 64'd3);
        chk("t5_no_issue", 64'(iv_cycles - iv0), 64'd0);

        // reset mid-fetch with a stale response afterwards
        auto_en = 1'b0;
        for (int j = 0; j < 10; j++) mem[j] = irm[79 - 8*j -: 8];
        do_reset(1'b0);
        for (int b = 0; b < 2; b++) begin
            wait_rd(ok, a);
            tick(1);
            imem_valid = 1'b1;
            imem_data  = mem[a[9:0]];
            tick(1);
            imem_valid = 1'b0;
        end
        wait_rd(ok, a);
        chk("t5_third_addr", a, 64'd2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 8'hC0;
        tick(1);
        imem_valid = 1'b0;
        chk("t5_restart_rd", 64'(imem_rd), 64'd1);
        chk("t5_restart_addr", imem_addr, 64'd0);
        tick(3);
        chk("t5_stat_aok", 64'(stat), 64'd0);
        chk("t5_pc_reset", pc_w, 64'd0);
        chk("t5_no_issue", 64'(issue_valid), 64'd0);

        // random programs with call/ret mix and 1-4 cycle memory latency
        auto_en = 1'b1;
        dly_max = 4;
        mem[0] = 8'h10;
        do_reset(1'b0);
        fetch_model(64'd0, 3);
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ic;
            base = 64'($urandom_range(DEPTH - 10, 0));
            case (i % 4)
                0:       ic = 4'h8;
                1:       ic = 4'h9;
                default: ic = 4'($urandom_range(11, 1));
            endcase
            mem[int'(base)] = {ic, 4'($urandom_range(15, 0))};
            for (int j = 1; j < 10; j++) mem[int'(base) + j] = 8'($urandom);
            give_pc(base);
            fetch_model(base, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
